// File: rtl/tiled_mm_sequencer_if.sv
// tiled_mm_sequencer_if: job port plus the A/B/output-buffer instruction and completion streams.
interface tiled_mm_sequencer_if #(
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int MATRIX_LENGTH_BITS = 13,
  parameter int ROWS_PROCESSORS = 2,
  parameter int COLS_PROCESSORS = 2
);
  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int LW = MATRIX_LENGTH_BITS;
  localparam int R = ROWS_PROCESSORS;
  localparam int C = COLS_PROCESSORS;
  logic [AW-1:0] a_memory_addr, b_memory_addr, c_memory_addr;
  logic [LW-1:0] m_length, k_length, n_length;
  logic c_by_row, instruction_valid, instruction_ready, done, error;
  logic [R-1:0] a_input_buffer_instruction_valids, a_input_buffer_instruction_readys;
  logic [R-1:0][AW-1:0] a_input_buffer_address_inputs;
  logic [R-1:0][LW-1:0] a_input_buffer_length_inputs, a_input_buffer_repeats_inputs;
  logic [C-1:0] b_input_buffer_instruction_valids, b_input_buffer_instruction_readys;
  logic [C-1:0][AW-1:0] b_input_buffer_address_inputs;
  logic [C-1:0][LW-1:0] b_input_buffer_length_inputs, b_input_buffer_repeats_inputs, b_input_buffer_stride_inputs;
  logic [R-1:0][C-1:0] output_buffer_instruction_valids, output_buffer_instruction_readys;
  logic [R-1:0][C-1:0][AW-1:0] output_buffer_address_inputs;
  logic [R-1:0][C-1:0] output_buffer_by_row_instructions;
  logic [R-1:0][C-1:0] output_buffer_completed_valids, output_buffer_completed_readys;
  modport master (
    input a_memory_addr, b_memory_addr, c_memory_addr, m_length, k_length, n_length, c_by_row, instruction_valid,
    input a_input_buffer_instruction_readys, b_input_buffer_instruction_readys,
    input output_buffer_instruction_readys, output_buffer_completed_valids,
    output instruction_ready, done, error,
    output a_input_buffer_instruction_valids, a_input_buffer_address_inputs, a_input_buffer_length_inputs, a_input_buffer_repeats_inputs,
    output b_input_buffer_instruction_valids, b_input_buffer_address_inputs, b_input_buffer_length_inputs, b_input_buffer_repeats_inputs,
    output b_input_buffer_stride_inputs,
    output output_buffer_instruction_valids, output_buffer_address_inputs, output_buffer_by_row_instructions, output_buffer_completed_readys
  );
  modport slave (
    output a_memory_addr, b_memory_addr, c_memory_addr, m_length, k_length, n_length, c_by_row, instruction_valid,
    output a_input_buffer_instruction_readys, b_input_buffer_instruction_readys,
    output output_buffer_instruction_readys, output_buffer_completed_valids,
    input instruction_ready, done, error,
    input a_input_buffer_instruction_valids, a_input_buffer_address_inputs, a_input_buffer_length_inputs, a_input_buffer_repeats_inputs,
    input b_input_buffer_instruction_valids, b_input_buffer_address_inputs, b_input_buffer_length_inputs, b_input_buffer_repeats_inputs,
    input b_input_buffer_stride_inputs,
    input output_buffer_instruction_valids, output_buffer_address_inputs, output_buffer_by_row_instructions, output_buffer_completed_readys
  );
endinterface

// File: rtl/tiled_mm_sequencer.sv
// tiled_mm_sequencer: splits C=A*B into TILE-edge row/column instruction streams for an R x C processor grid.
module tiled_mm_sequencer #(
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int MAX_MATRIX_LENGTH = 4096,
  parameter int MATRIX_LENGTH_BITS = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int TILE = 4,
  parameter int ROWS_PROCESSORS = 2,
  parameter int COLS_PROCESSORS = 2
) (
  input logic clk,
  input logic reset,
  tiled_mm_sequencer_if.master bus
);
  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int LW = MATRIX_LENGTH_BITS;
  localparam int R = ROWS_PROCESSORS;
  localparam int C = COLS_PROCESSORS;
  localparam int LT = $clog2(TILE);
  localparam int LR = $clog2(R);
  localparam int LC = $clog2(C);
  localparam logic [LW-1:0] ONE = LW'(1);
  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
  state_t state, state_n;
  logic [AW-1:0] a_base, b_base, c_base, tile_k, tile_n, a_step, row_step, col_step, acc_a, acc_o;
  logic [LW-1:0] m_len, k_len, n_len, p_n, q_n, q_last;
  logic by_row, rep_one, done, error, bad, run, load, fin;
  logic [R-1:0][AW-1:0] a_row0, o_row0, aa;
  logic [R-1:0][LW-1:0] ap;
  logic [R-1:0] a_v, a_fire;
  logic [C-1:0][AW-1:0] ba;
  logic [C-1:0][LW-1:0] bq, bp;
  logic [C-1:0] b_v, b_fire, b_wrap;
  logic [R-1:0][C-1:0][AW-1:0] oa, orow;
  logic [R-1:0][C-1:0][LW-1:0] oq, op, dq, dp;
  logic [R-1:0][C-1:0] o_v, o_fire, o_wrap, d_rdy, d_fire, d_wrap;
  assign run = state == RUN;
  assign p_n = m_len >> (LT + LR);
  assign q_n = n_len >> (LT + LC);
  assign q_last = q_n - ONE;
  // TILE, R and C are powers of two, so "M/TILE divisible by R" is "M divisible by TILE*R"
  assign bad = m_len == '0 || k_len == '0 || n_len == '0 ||
               (m_len & LW'(TILE * R - 1)) != '0 || (n_len & LW'(TILE * C - 1)) != '0;
  assign load = state == SETUP && !bad;
  assign tile_k = AW'(k_len) << LT;
  assign tile_n = AW'(n_len) << LT;
  assign a_step = tile_k << LR;
  assign row_step = tile_n << LR;
  assign col_step = AW'(C) << LT;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = bus.instruction_valid ? SETUP : IDLE;
    else if (state == SETUP) state_n = bad ? IDLE : RUN;
    else state_n = fin ? IDLE : RUN;
  end
  always_comb begin
    acc_a = a_base;
    acc_o = c_base;
    fin = run;
    a_row0 = '0; o_row0 = '0; a_v = '0; a_fire = '0;
    b_v = '0; b_fire = '0; b_wrap = '0;
    o_v = '0; o_fire = '0; o_wrap = '0; d_rdy = '0; d_fire = '0; d_wrap = '0;
    for (int r = 0; r < R; r++) begin
      a_row0[r] = acc_a;
      o_row0[r] = acc_o;
      acc_a = acc_a + tile_k;
      acc_o = acc_o + tile_n;
      a_v[r] = run && ap[r] != p_n;
      a_fire[r] = a_v[r] && bus.a_input_buffer_instruction_readys[r];
      fin = fin && ap[r] == p_n;
    end
    for (int c = 0; c < C; c++) begin
      b_v[c] = run && bp[c] != p_n;
      b_fire[c] = b_v[c] && bus.b_input_buffer_instruction_readys[c];
      b_wrap[c] = bq[c] == q_last;
      fin = fin && bp[c] == p_n;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        o_v[r][c] = run && op[r][c] != p_n;
        o_fire[r][c] = o_v[r][c] && bus.output_buffer_instruction_readys[r][c];
        o_wrap[r][c] = oq[r][c] == q_last;
        d_rdy[r][c] = run && dp[r][c] != p_n;
        d_fire[r][c] = d_rdy[r][c] && bus.output_buffer_completed_valids[r][c];
        d_wrap[r][c] = dq[r][c] == q_last;
        fin = fin && op[r][c] == p_n && dp[r][c] == p_n;
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {a_base, b_base, c_base} <= '0;
      {m_len, k_len, n_len} <= '0;
      {by_row, rep_one, done, error} <= '0;
    end else begin
      if (state == IDLE && bus.instruction_valid) begin
        {a_base, b_base, c_base} <= {bus.a_memory_addr, bus.b_memory_addr, bus.c_memory_addr};
        {m_len, k_len, n_len} <= {bus.m_length, bus.k_length, bus.n_length};
        by_row <= bus.c_by_row;
        done <= 1'b0;
        error <= 1'b0;
      end
      if (state == SETUP) begin
        error <= bad;
        rep_one <= !bad;
      end
      if (fin) done <= 1'b1;
    end
  // orow tracks the current tile-row start of each output stream (column offset included)
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {aa, ap, ba, bq, bp} <= '0;
      {oa, orow, oq, op, dq, dp} <= '0;
    end else if (load) begin
      {ap, bq, bp, oq, op, dq, dp} <= '0;
      aa <= a_row0;
      for (int c = 0; c < C; c++) ba[c] <= b_base + (AW'(c) << LT);
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          oa[r][c] <= o_row0[r] + (AW'(c) << LT);
          orow[r][c] <= o_row0[r] + (AW'(c) << LT);
        end
    end else begin
      for (int r = 0; r < R; r++)
        if (a_fire[r]) begin
          ap[r] <= ap[r] + ONE;
          aa[r] <= aa[r] + a_step;
        end
      for (int c = 0; c < C; c++)
        if (b_fire[c]) begin
          bq[c] <= b_wrap[c] ? '0 : bq[c] + ONE;
          bp[c] <= bp[c] + LW'(b_wrap[c]);
          ba[c] <= b_wrap[c] ? b_base + (AW'(c) << LT) : ba[c] + col_step;
        end
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          if (o_fire[r][c]) begin
            oq[r][c] <= o_wrap[r][c] ? '0 : oq[r][c] + ONE;
            op[r][c] <= op[r][c] + LW'(o_wrap[r][c]);
            oa[r][c] <= o_wrap[r][c] ? orow[r][c] + row_step : oa[r][c] + col_step;
            if (o_wrap[r][c]) orow[r][c] <= orow[r][c] + row_step;
          end
          if (d_fire[r][c]) begin
            dq[r][c] <= d_wrap[r][c] ? '0 : dq[r][c] + ONE;
            dp[r][c] <= dp[r][c] + LW'(d_wrap[r][c]);
          end
        end
    end
  assign bus.instruction_ready = state == IDLE;
  assign bus.done = done;
  assign bus.error = error;
  assign bus.a_input_buffer_instruction_valids = a_v;
  assign bus.a_input_buffer_address_inputs = aa;
  assign bus.a_input_buffer_length_inputs = {R{k_len}};
  assign bus.a_input_buffer_repeats_inputs = {R{q_n}};
  assign bus.b_input_buffer_instruction_valids = b_v;
  assign bus.b_input_buffer_address_inputs = ba;
  assign bus.b_input_buffer_length_inputs = {C{k_len}};
  assign bus.b_input_buffer_repeats_inputs = {C{LW'(rep_one)}};
  assign bus.b_input_buffer_stride_inputs = {C{n_len}};
  assign bus.output_buffer_instruction_valids = o_v;
  assign bus.output_buffer_address_inputs = oa;
  assign bus.output_buffer_by_row_instructions = {(R * C){by_row}};
  assign bus.output_buffer_completed_readys = d_rdy;
endmodule

// File: tb/tb_tiled_mm_sequencer.sv
// tb_tiled_mm_sequencer: randomized job bench; expected instruction streams are queued per job and
// popped by an independent monitor as the sequencer issues them.
module tb_tiled_mm_sequencer;
  localparam int AW = 64, LW = 13, T = 4, R = 2, C = 2;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  tiled_mm_sequencer_if #(.MEMORY_ADDRESS_BITS(AW), .MATRIX_LENGTH_BITS(LW), .ROWS_PROCESSORS(R), .COLS_PROCESSORS(C)) bus ();
  tiled_mm_sequencer #(.MEMORY_ADDRESS_BITS(AW), .MAX_MATRIX_LENGTH(4096), .MATRIX_LENGTH_BITS(LW), .TILE(T),
                       .ROWS_PROCESSORS(R), .COLS_PROCESSORS(C)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    int idx;
    logic [AW-1:0] addr;
    logic [LW-1:0] len, rep, stride;
    logic by_row;
  } item_t;
  item_t qa[$], qb[$], qo[$];
  int total = 0, bad = 0;
  int pend[R*C], comps[R*C];
  int b0_fires = 0;
  int mode = 0;
  logic [AW-1:0] hold_addr[R];
  logic held[R];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input item_t q[$], input int idx);
    foreach (q[i]) if (q[i].idx == idx) return i;
    return -1;
  endfunction

  function automatic logic any_valid();
    return |bus.a_input_buffer_instruction_valids || |bus.b_input_buffer_instruction_valids ||
           |bus.output_buffer_instruction_valids;
  endfunction

  // monitor: pops the expected item for a stream whenever that stream transfers
  initial forever begin
    int i;
    logic v, rd;
    @(negedge clk);
    if (!reset) begin
      for (int r = 0; r < R; r++) begin
        v = bus.a_input_buffer_instruction_valids[r];
        rd = bus.a_input_buffer_instruction_readys[r];
        if (held[r] && v) chk("a_hold_addr", bus.a_input_buffer_address_inputs[r], hold_addr[r]);
        held[r] = v && !rd;
        hold_addr[r] = bus.a_input_buffer_address_inputs[r];
        i = find(qa, r);
        if (v && i < 0) chk("a_valid_unexpected", AW'(v), '0);
        else if (v && rd) begin
          chk("a_addr", bus.a_input_buffer_address_inputs[r], qa[i].addr);
          chk("a_len", AW'(bus.a_input_buffer_length_inputs[r]), AW'(qa[i].len));
          chk("a_rep", AW'(bus.a_input_buffer_repeats_inputs[r]), AW'(qa[i].rep));
          qa.delete(i);
        end
      end
      for (int c = 0; c < C; c++) begin
        v = bus.b_input_buffer_instruction_valids[c];
        rd = bus.b_input_buffer_instruction_readys[c];
        i = find(qb, c);
        if (v && i < 0) chk("b_valid_unexpected", AW'(v), '0);
        else if (v && rd) begin
          chk("b_addr", bus.b_input_buffer_address_inputs[c], qb[i].addr);
          chk("b_len", AW'(bus.b_input_buffer_length_inputs[c]), AW'(qb[i].len));
          chk("b_rep", AW'(bus.b_input_buffer_repeats_inputs[c]), AW'(qb[i].rep));
          chk("b_stride", AW'(bus.b_input_buffer_stride_inputs[c]), AW'(qb[i].stride));
          qb.delete(i);
          if (c == 0) b0_fires++;
        end
      end
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          v = bus.output_buffer_instruction_valids[r][c];
          rd = bus.output_buffer_instruction_readys[r][c];
          i = find(qo, r * C + c);
          if (v && i < 0) chk("o_valid_unexpected", AW'(v), '0);
          else if (v && rd) begin
            chk("o_addr", bus.output_buffer_address_inputs[r][c], qo[i].addr);
            chk("o_by_row", AW'(bus.output_buffer_by_row_instructions[r][c]), AW'(qo[i].by_row));
            qo.delete(i);
            pend[r*C+c]++;
          end
          if (bus.output_buffer_completed_valids[r][c] && bus.output_buffer_completed_readys[r][c]) begin
            comps[r*C+c]++;
            pend[r*C+c]--;
          end
        end
    end
  end

  // buffer models: random readys, completions offered only for tiles already issued
  initial forever begin
    @(posedge clk);
    #1;
    for (int r = 0; r < R; r++)
      bus.a_input_buffer_instruction_readys[r] = mode == 1 ? (r != 0) : ($urandom_range(3) != 0);
    for (int c = 0; c < C; c++)
      bus.b_input_buffer_instruction_readys[c] = mode == 1 ? 1'b1 : ($urandom_range(3) != 0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        bus.output_buffer_instruction_readys[r][c] = mode == 1 ? 1'b1 : ($urandom_range(3) != 0);
        bus.output_buffer_completed_valids[r][c] = pend[r*C+c] > 0 && $urandom_range(2) != 0;
      end
  end

  task automatic clear_model();
    qa.delete(); qb.delete(); qo.delete();
    for (int i = 0; i < R * C; i++) begin pend[i] = 0; comps[i] = 0; end
    for (int r = 0; r < R; r++) held[r] = 1'b0;
  endtask

  task automatic expect_job(input logic [AW-1:0] a, b, cb, input int m, k, n, input logic byrow);
    int p_n, q_n;
    p_n = m / (T * R);
    q_n = n / (T * C);
    for (int p = 0; p < p_n; p++)
      for (int r = 0; r < R; r++)
        qa.push_back('{r, a + AW'((r + R * p) * T * k), LW'(k), LW'(q_n), '0, 1'b0});
    for (int p = 0; p < p_n; p++)
      for (int q = 0; q < q_n; q++) begin
        for (int c = 0; c < C; c++)
          qb.push_back('{c, b + AW'((c + C * q) * T), LW'(k), LW'(1), LW'(n), 1'b0});
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            qo.push_back('{r * C + c, cb + AW'((r + R * p) * T * n) + AW'((c + C * q) * T), '0, '0, '0, byrow});
      end
  endtask

  task automatic issue(input logic [AW-1:0] a, b, cb, input int m, k, n, input logic byrow);
    int cnt = 0;
    @(posedge clk);
    #1;
    bus.a_memory_addr = a; bus.b_memory_addr = b; bus.c_memory_addr = cb;
    bus.m_length = LW'(m); bus.k_length = LW'(k); bus.n_length = LW'(n);
    bus.c_by_row = byrow;
    bus.instruction_valid = 1'b1;
    while (!bus.instruction_ready && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("instr_ready_wait", AW'(bus.instruction_ready), 1);
    @(posedge clk);
    #1;
    bus.instruction_valid = 1'b0;
  endtask

  // hold_bp: keep A0 not-ready for 10 cycles right after the job starts
  task automatic run_job(input logic [AW-1:0] a, b, cb, input int m, k, n, input logic byrow, input logic hold_bp);
    int cnt = 0, p_n, q_n, a0_left;
    logic ok;
    ok = m > 0 && k > 0 && n > 0 && m % (T * R) == 0 && n % (T * C) == 0;
    p_n = m / (T * R);
    q_n = n / (T * C);
    clear_model();
    if (ok) expect_job(a, b, cb, m, k, n, byrow);
    if (hold_bp) mode = 1;
    issue(a, b, cb, m, k, n, byrow);
    chk("setup_no_valid", AW'(any_valid()), '0);
    chk("accept_clears_done", AW'(bus.done), '0);
    if (!ok) begin
      while (!bus.error && cnt < 3) begin @(posedge clk); #1; cnt++; end
      chk("reject_error", AW'(bus.error), 1);
      chk("reject_done", AW'(bus.done), '0);
      chk("reject_ready", AW'(bus.instruction_ready), 1);
      repeat (4) @(posedge clk);
      #1;
      chk("reject_no_valid", AW'(any_valid()), '0);
      chk("reject_error_held", AW'(bus.error), 1);
      return;
    end
    @(posedge clk);
    #1;
    chk("first_valid_latency", AW'(&bus.a_input_buffer_instruction_valids), 1);
    if (hold_bp) begin
      b0_fires = 0;
      repeat (10) @(posedge clk);
      #1;
      a0_left = 0;
      foreach (qa[i]) if (qa[i].idx == 0) a0_left++;
      chk("bp_a0_not_issued", AW'(a0_left), AW'(p_n));
      chk("bp_a0_valid_held", AW'(bus.a_input_buffer_instruction_valids[0]), 1);
      chk("bp_others_progress", AW'(b0_fires > 0), 1);
      mode = 0;
    end
    cnt = 0;
    while (!bus.done && cnt < 4000) begin @(posedge clk); #1; cnt++; end
    chk("job_done", AW'(bus.done), 1);
    chk("job_error", AW'(bus.error), '0);
    chk("job_ready", AW'(bus.instruction_ready), 1);
    chk("a_left", AW'(qa.size()), '0);
    chk("b_left", AW'(qb.size()), '0);
    chk("o_left", AW'(qo.size()), '0);
    for (int i = 0; i < R * C; i++) chk("completions", AW'(comps[i]), AW'(p_n * q_n));
    chk("comp_ready_idle", AW'(bus.output_buffer_completed_readys), '0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_held", AW'(bus.done), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valids"}, AW'(any_valid()), '0);
    chk({tag, "_comp_readys"}, AW'(bus.output_buffer_completed_readys), '0);
    chk({tag, "_done"}, AW'(bus.done), '0);
    chk({tag, "_error"}, AW'(bus.error), '0);
    chk({tag, "_a_addr"}, AW'(|bus.a_input_buffer_address_inputs), '0);
    chk({tag, "_b_addr"}, AW'(|bus.b_input_buffer_address_inputs), '0);
    chk({tag, "_o_addr"}, AW'(|bus.output_buffer_address_inputs), '0);
    chk({tag, "_lengths"}, AW'(|bus.a_input_buffer_length_inputs | |bus.b_input_buffer_length_inputs), '0);
    chk({tag, "_repeats"}, AW'(|bus.a_input_buffer_repeats_inputs | |bus.b_input_buffer_repeats_inputs), '0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra, rb, rc;
    int bad_m[5] = '{6, 8, 8, 4, 0};
    int bad_k[5] = '{4, 0, 4, 4, 4};
    int bad_n[5] = '{8, 8, 12, 8, 8};
    clear_model();
    bus.instruction_valid = 1'b0;
    bus.a_memory_addr = '0; bus.b_memory_addr = '0; bus.c_memory_addr = '0;
    bus.m_length = '0; bus.k_length = '0; bus.n_length = '0; bus.c_by_row = 1'b0;
    bus.a_input_buffer_instruction_readys = '0;
    bus.b_input_buffer_instruction_readys = '0;
    bus.output_buffer_instruction_readys = '0;
    bus.output_buffer_completed_valids = '0;
    #2 reset = 1'b1;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ready", AW'(bus.instruction_ready), 1);
    run_job(64'h100, 64'h200, 64'h300, 8, 4, 8, 1'b1, 1'b0);
    run_job(64'h1000, 64'h2000, 64'h3000, 16, 8, 16, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_job(64'h100, 64'h200, 64'h300, bad_m[i], bad_k[i], bad_n[i], 1'b0, 1'b0);
    run_job(64'h4000, 64'h5000, 64'h6000, 16, 8, 16, 1'b1, 1'b1);
    run_job(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFE0, 16, 4, 16, 1'b0, 1'b0);
    clear_model();
    expect_job(64'h100, 64'h200, 64'h300, 24, 8, 24, 1'b0);
    issue(64'h100, 64'h200, 64'h300, 24, 8, 24, 1'b0);
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_values("midrun");
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("midrun_ready", AW'(bus.instruction_ready), 1);
    run_job(64'h100, 64'h200, 64'h300, 8, 4, 8, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      run_job(ra, rb, rc, T * R * $urandom_range(1, 3), $urandom_range(1, 12), T * C * $urandom_range(1, 3),
              1'($urandom_range(1)), 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
